// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and defaults for the SUBLEQ RAM port arbiter.
// Holds the access-sequencer state encoding and the requester IDs.
package ram_port_arbiter_pkg;

   localparam int ADR_W_DEF = 8;
   localparam int DAT_W_DEF = 8;

   // Requester IDs double as bit positions in the arbiter request vector
   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_HST = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, and on contention
// the requester that was not served last wins.
module rr_arb2
   import ram_port_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       owner,
   output logic       valid
);

   always_comb begin
      valid = |req;
      owner = REQ_CPU;
      if (req == 2'b11) begin
         owner = ~last;
      end else if (req[REQ_HST]) begin
         owner = REQ_HST;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the SUBLEQ program/data RAM between the CPU control unit and the host
// loader, sequencing each granted access through SETUP/STROBE/HOLD on the RAM pins.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int ADR_W    = ADR_W_DEF,
   parameter int DAT_W    = DAT_W_DEF,
   parameter int STRB_CYC = 1
)(
   input  logic             clk,
   input  logic             res,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [ADR_W-1:0] cpu_adr,
   input  logic [DAT_W-1:0] cpu_wdat,
   output logic             cpu_gnt,
   output logic             cpu_done,
   output logic [DAT_W-1:0] cpu_rdat,
   input  logic             hst_req,
   input  logic             hst_we,
   input  logic [ADR_W-1:0] hst_adr,
   input  logic [DAT_W-1:0] hst_wdat,
   output logic             hst_gnt,
   output logic             hst_done,
   output logic [DAT_W-1:0] hst_rdat,
   output logic [ADR_W-1:0] ram_adr,
   output logic [DAT_W-1:0] ram_wdat,
   output logic             ram_dat_oe,
   input  logic [DAT_W-1:0] ram_rdat,
   output logic             ram_ena,
   output logic             ram_ope,
   output logic             ram_ctl,
   output logic             busy
);

   arb_state_t       state, next_state;
   logic [1:0]       strb_cnt;
   logic             strobe_last;
   logic             owner_q, last_q, we_q;
   logic             pick_owner, pick_valid;
   logic             grant;
   logic             sel_we;
   logic [ADR_W-1:0] sel_adr;
   logic [DAT_W-1:0] sel_wdat;
   logic             owner_nxt, we_nxt;

   rr_arb2 u_rr_arb2 (
      .req   ({hst_req, cpu_req}),
      .last  (last_q),
      .owner (pick_owner),
      .valid (pick_valid)
   );

   assign grant       = (state == ST_IDLE) && pick_valid;
   assign strobe_last = (strb_cnt == 2'(STRB_CYC - 1));
   assign sel_we      = (pick_owner == REQ_HST) ? hst_we   : cpu_we;
   assign sel_adr     = (pick_owner == REQ_HST) ? hst_adr  : cpu_adr;
   assign sel_wdat    = (pick_owner == REQ_HST) ? hst_wdat : cpu_wdat;
   assign owner_nxt   = grant ? pick_owner : owner_q;
   assign we_nxt      = grant ? sel_we     : we_q;
   assign busy        = (state != ST_IDLE);

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (pick_valid) next_state = ST_SETUP;
         ST_SETUP:  next_state = ST_STROBE;
         ST_STROBE: if (strobe_last) next_state = ST_HOLD;
         ST_HOLD:   next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   // Pins are registered from the next state so they toggle exactly on state entry
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         ram_ena    <= 1'b1;
         ram_ope    <= 1'b1;
         ram_ctl    <= 1'b1;
         ram_dat_oe <= 1'b0;
         cpu_gnt    <= 1'b0;
         hst_gnt    <= 1'b0;
         cpu_done   <= 1'b0;
         hst_done   <= 1'b0;
      end else begin
         ram_ena    <= (next_state == ST_IDLE);
         ram_ope    <= ~(~we_nxt && ((next_state == ST_SETUP) || (next_state == ST_STROBE)));
         ram_ctl    <= ~(we_nxt && (next_state == ST_STROBE));
         ram_dat_oe <= we_nxt && (next_state != ST_IDLE);
         cpu_gnt    <= (next_state != ST_IDLE) && (owner_nxt == REQ_CPU);
         hst_gnt    <= (next_state != ST_IDLE) && (owner_nxt == REQ_HST);
         cpu_done   <= (next_state == ST_HOLD) && (owner_nxt == REQ_CPU);
         hst_done   <= (next_state == ST_HOLD) && (owner_nxt == REQ_HST);
      end
   end

   // Address, data and ownership are frozen at grant so they cannot move under the strobe
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         ram_adr  <= '0;
         ram_wdat <= '0;
         owner_q  <= REQ_CPU;
         we_q     <= 1'b0;
         last_q   <= REQ_HST;
         strb_cnt <= 2'd0;
      end else begin
         if (grant) begin
            ram_adr  <= sel_adr;
            ram_wdat <= sel_wdat;
            owner_q  <= pick_owner;
            we_q     <= sel_we;
            last_q   <= pick_owner;
         end
         if ((state == ST_STROBE) && !strobe_last) begin
            strb_cnt <= strb_cnt + 2'd1;
         end else begin
            strb_cnt <= 2'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         cpu_rdat <= '0;
         hst_rdat <= '0;
      end else if ((state == ST_STROBE) && strobe_last && !we_q) begin
         if (owner_q == REQ_CPU) begin
            cpu_rdat <= ram_rdat;
         end else begin
            hst_rdat <= ram_rdat;
         end
      end
   end

endmodule
